// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the byte-wide RAM arbiter.
// Provides the access-size encoding, the arbiter FSM states, the default RAM
// address width and a helper that maps an access size to its byte count.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 17;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR,
        DONE
    } state_e;

    // 2'b11 is treated as a word access as well.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        return size_e'(sz) == SZ_BYTE ? 3'd1 : size_e'(sz) == SZ_HALF ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_serializer.sv
// mem_arbiter_byte_serializer: walks one access across the byte-wide RAM port.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          latch addr/wdata and drive byte 0 on the next cycle
//   step           advance to the next byte and capture the current read byte
//   addr, wdata    request address and store data (latched on start)
//   din            RAM read byte, valid one cycle after its address
//   cnt            number of steps taken since start
//   ram_addr       registered RAM byte address
//   ram_dout       registered store byte
//   rd_next        assembled read word including the byte on din this cycle
module mem_arbiter_byte_serializer
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [7:0]        din,
    output logic [2:0]        cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic [31:0]       rd_next
);

    logic [31:0] base;
    logic [31:0] wr_word;
    logic [31:0] rdata;
    logic [2:0]  nxt;

    assign nxt = cnt + 3'd1;

    // The byte on din belongs to the address driven one step earlier.
    always_comb begin
        rd_next = rdata;
        if (cnt != 3'd0) rd_next[{cnt - 3'd1, 3'b000} +: 8] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            base     <= '0;
            wr_word  <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_dout <= '0;
        end else if (start) begin
            cnt      <= '0;
            base     <= addr;
            wr_word  <= wdata;
            rdata    <= '0;
            ram_addr <= addr[ADDR_W-1:0];
            ram_dout <= wdata[7:0];
        end else if (step) begin
            cnt      <= nxt;
            rdata    <= rd_next;
            ram_addr <= ADDR_W'(base + 32'(nxt));
            ram_dout <= wr_word[{nxt[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM between fetch and load/store.
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   if_req/if_addr/if_cancel          fetch request, address and abort
//   if_ack/if_data                    fetch completion pulse and word
//   mem_req/mem_we/mem_size/mem_addr  load/store request (size 00/01/1x)
//   mem_wdata                         store data, low bytes used
//   mem_ack/mem_rdata                 completion pulse and zero-extended load data
//   stallreq_if/stallreq_mem          per-requester stall requests
//   ram_addr/ram_wr/ram_dout/ram_din  byte RAM port (registered outputs)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_cancel,
    output logic              if_ack,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_e      state;
    logic [2:0]  n;
    logic [2:0]  cnt;
    logic [31:0] rd_next;
    logic        grant_mem;
    logic        grant_if;
    logic        step;

    // Load/store always wins; a fetch raised together with its cancel is not taken.
    always_comb begin
        grant_mem = state == IDLE && mem_req;
        grant_if  = state == IDLE && !mem_req && if_req && !if_cancel;
        step      = state == IF_RD || state == MEM_RD || state == MEM_WR;
    end

    assign stallreq_if  = if_req & ~if_ack & ~if_cancel;
    assign stallreq_mem = mem_req & ~mem_ack;

    mem_arbiter_byte_serializer #(.ADDR_W(ADDR_W)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .start   (grant_mem | grant_if),
        .step    (step),
        .addr    (mem_req ? mem_addr : if_addr),
        .wdata   (mem_wdata),
        .din     (ram_din),
        .cnt     (cnt),
        .ram_addr(ram_addr),
        .ram_dout(ram_dout),
        .rd_next (rd_next)
    );

    // Reads stay one step past the last address to capture the final byte;
    // writes finish as soon as the last byte has been strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            ram_wr    <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    ram_wr  <= grant_mem & mem_we;
                    if (grant_mem) begin
                        n     <= size_bytes(mem_size);
                        state <= mem_we ? MEM_WR : MEM_RD;
                    end else if (grant_if) begin
                        n     <= 3'd4;
                        state <= IF_RD;
                    end
                end
                IF_RD: begin
                    if (if_cancel) state <= IDLE;
                    else if (cnt == n) begin
                        state   <= DONE;
                        if_ack  <= 1'b1;
                        if_data <= rd_next;
                    end
                end
                MEM_RD: begin
                    if (cnt == n) begin
                        state     <= DONE;
                        mem_ack   <= 1'b1;
                        mem_rdata <= rd_next;
                    end
                end
                MEM_WR: begin
                    if (cnt == n - 3'd1) begin
                        state   <= DONE;
                        ram_wr  <= 1'b0;
                        mem_ack <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    ram_wr  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a byte-array model.
module tb_mem_arbiter;

    localparam int AW   = 17;
    localparam int SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_cancel = 1'b0;
    logic          if_ack;
    logic [31:0]   if_data;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_size = '0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          stallreq_if;
    logic          stallreq_mem;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0] ram     [SIZE];
    logic [7:0] ref_mem [SIZE];

    int checks = 0;
    int failures = 0;

    logic        pm_we;
    logic [1:0]  pm_sz;
    logic [31:0] pm_a;
    logic [31:0] pm_wd;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_cancel   (if_cancel),
        .if_ack      (if_ack),
        .if_data     (if_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stallreq_if (stallreq_if),
        .stallreq_mem(stallreq_mem),
        .ram_addr    (ram_addr),
        .ram_wr      (ram_wr),
        .ram_dout    (ram_dout),
        .ram_din     (ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [AW-1:0] idx(input logic [31:0] a, input int i);
        return AW'(a + 32'(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int k);
        for (int i = 0; i < k; i++) begin
            tick();
            chk("quiet_if_ack", 32'(if_ack), 32'd0);
            chk("quiet_mem_ack", 32'(mem_ack), 32'd0);
            chk("quiet_ram_wr", 32'(ram_wr), 32'd0);
        end
    endtask

    // Current cycle is the grant cycle t; ends in the IDLE cycle after the ack.
    task automatic do_mem(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] exp_d;
        n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        exp_d = '0;
        mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
        #1;
        chk("mem_stall_t", 32'(stallreq_mem), 32'd1);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("mem_ram_addr", 32'(ram_addr), 32'(idx(a, i)));
            chk("mem_ram_wr", 32'(ram_wr), 32'(we));
            chk("mem_stall", 32'(stallreq_mem), 32'd1);
            chk("if_stall_in_mem", 32'(stallreq_if), 32'(if_req));
            chk("mem_ack_early", 32'(mem_ack), 32'd0);
            if (we) begin
                chk("mem_ram_dout", 32'(ram_dout), 32'(wd[8*i +: 8]));
                ref_mem[idx(a, i)] = wd[8*i +: 8];
            end else exp_d[8*i +: 8] = ref_mem[idx(a, i)];
        end
        if (!we) begin
            tick();
            chk("mem_ack_early", 32'(mem_ack), 32'd0);
        end
        tick();
        chk("mem_ack", 32'(mem_ack), 32'd1);
        chk("mem_ack_if_ack", 32'(if_ack), 32'd0);
        chk("mem_ack_ram_wr", 32'(ram_wr), 32'd0);
        chk("mem_ack_stall", 32'(stallreq_mem), 32'd0);
        if (!we) chk("mem_rdata", mem_rdata, exp_d);
        tick();
        mem_req = 1'b0;
        chk("mem_ack_pulse", 32'(mem_ack), 32'd0);
        if (!we) chk("mem_rdata_hold", mem_rdata, exp_d);
    endtask

    // mem_at=k raises the pending pm_* load/store in cycle t+k of the fetch.
    task automatic do_if(input logic [31:0] a, input int mem_at);
        logic [31:0] exp_d;
        exp_d = '0;
        if_req = 1'b1; if_addr = a; if_cancel = 1'b0;
        #1;
        chk("if_stall_t", 32'(stallreq_if), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("if_ram_addr", 32'(ram_addr), 32'(idx(a, i)));
            chk("if_ram_wr", 32'(ram_wr), 32'd0);
            chk("if_stall", 32'(stallreq_if), 32'd1);
            chk("mem_stall_wait", 32'(stallreq_mem), 32'(mem_req));
            chk("if_ack_early", 32'(if_ack), 32'd0);
            exp_d[8*i +: 8] = ref_mem[idx(a, i)];
            if (mem_at == i + 1) begin
                mem_req = 1'b1; mem_we = pm_we; mem_size = pm_sz; mem_addr = pm_a; mem_wdata = pm_wd;
            end
        end
        tick();
        chk("if_ack_early", 32'(if_ack), 32'd0);
        chk("if_stall_t5", 32'(stallreq_if), 32'd1);
        tick();
        chk("if_ack", 32'(if_ack), 32'd1);
        chk("if_ack_mem_ack", 32'(mem_ack), 32'd0);
        chk("if_data", if_data, exp_d);
        chk("if_ack_stall", 32'(stallreq_if), 32'd0);
        tick();
        if_req = 1'b0;
        chk("if_ack_pulse", 32'(if_ack), 32'd0);
        chk("if_data_hold", if_data, exp_d);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < SIZE; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
        ram[17'h1FFFF] = 8'h80;
        for (int i = 0; i < 4; i++) ref_mem[17'h100 + i] = ram[17'h100 + i];
        ref_mem[17'h1FFFF] = 8'h80;

        tick(); tick(); tick();
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        do_if(32'h100, 0);
        chk("fetch_word", if_data, 32'h0000_0513);
        quiet(2);

        do_mem(1'b0, 2'b00, 32'h0001_FFFF, 32'd0);
        chk("load_byte_top", mem_rdata, 32'h0000_0080);
        quiet(2);

        do_mem(1'b1, 2'b01, 32'h10, 32'h0000_BEEF);
        quiet(1);
        do_mem(1'b0, 2'b01, 32'h10, 32'd0);
        chk("load_half_beef", mem_rdata, 32'h0000_BEEF);
        quiet(2);

        if_req = 1'b1; if_addr = 32'h300;
        do_mem(1'b1, 2'b10, 32'h40, $urandom);
        do_if(32'h300, 0);
        quiet(3);

        if_req = 1'b1; if_addr = 32'h100;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cancel_ram_addr", 32'(ram_addr), 32'(idx(32'h100, i)));
            chk("cancel_if_ack", 32'(if_ack), 32'd0);
        end
        if_cancel = 1'b1;
        #1;
        chk("cancel_stall", 32'(stallreq_if), 32'd0);
        tick();
        if_cancel = 1'b0;
        chk("cancel_no_ack", 32'(if_ack), 32'd0);
        chk("cancel_ram_wr", 32'(ram_wr), 32'd0);
        do_if(32'h200, 0);
        quiet(2);

        if_req = 1'b1; if_cancel = 1'b1; if_addr = 32'h0001_FFFE;
        #1;
        chk("idle_cancel_stall", 32'(stallreq_if), 32'd0);
        tick();
        do_if(32'h0001_FFFE, 0);
        quiet(2);

        pm_we = 1'b0; pm_sz = 2'b11; pm_a = 32'hFFFF_FFFE; pm_wd = '0;
        do_if(32'h400, 2);
        do_mem(pm_we, pm_sz, pm_a, pm_wd);
        quiet(2);

        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h80; mem_wdata = 32'hA1B2_C3D4;
        tick();
        chk("rst_mid_wr", 32'(ram_wr), 32'd1);
        ref_mem[17'h80] = 8'hD4;
        tick();
        rst = 1'b1;
        ref_mem[17'h81] = 8'hC3;
        tick();
        rst = 1'b0; mem_req = 1'b0;
        chk("rst_mid_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_mid_mem_ack", 32'(mem_ack), 32'd0);
        chk("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_mid_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_mid_if_data", if_data, 32'd0);
        chk("rst_mid_mem_rdata", mem_rdata, 32'd0);
        quiet(3);
        do_mem(1'b0, 2'b10, 32'h80, 32'd0);
        quiet(1);

        for (int k = 0; k < 60; k++) begin
            a = $urandom_range(0, 3) == 0 ? 32'h0001_FFFC + 32'($urandom_range(0, 7)) :
                $urandom_range(0, 1) == 0 ? 32'($urandom_range(0, 63)) : $urandom;
            d = $urandom;
            case ($urandom_range(0, 2))
                0: do_if(a, 0);
                1: do_mem(1'b1, 2'($urandom_range(0, 3)), a, d);
                default: do_mem(1'b0, 2'($urandom_range(0, 3)), a, d);
            endcase
            if ($urandom_range(0, 1) == 1) quiet(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
